// File: rtl/uart_pkg.sv
// Shared types and helpers for the Arty UART blocks.
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 868;  // 100 MHz / 115200

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } rx_state_e;

  function automatic logic parity_calc(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
endpackage

// File: rtl/arty_uart_sync2.sv
// Generic two-flop synchroniser with a configurable reset value, for any
// asynchronous board input (serial line, buttons, switches).
module arty_uart_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/arty_uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, one stop bit,
// 3-sample majority vote mid-bit, single-entry valid/ready holding register.
module arty_uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_err_o,
  output logic       busy_o
);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
  localparam logic        ODD  = (PARITY_ODD != 0);

  logic        rx_s;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  samp_q, samp_d;
  logic        pflag_q, pflag_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        perr_q, perr_d;
  logic        ovr_q, ovr_d;

  logic in_frame, decide, maj, done, accept;

  arty_uart_sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_i),
    .q_o (rx_s)
  );

  assign in_frame = (state_q == START) || (state_q == DATA) ||
                    (state_q == PARITY) || (state_q == STOP);
  assign decide   = in_frame && (cnt_q == HALF + 16'd1);
  // samp_q[1] taken at HALF-1, samp_q[0] at HALF, live rx_s at HALF+1
  assign maj      = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);
  assign done     = decide && (state_q == STOP);
  assign accept   = !valid_q || rx_ready_i;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rx_s) state_d = START;
      START:     if (decide) state_d = maj ? IDLE : DATA;
      DATA:      if (decide && bit_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:    if (decide) state_d = STOP;
      STOP:      if (decide) state_d = maj ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    samp_d  = samp_q;
    pflag_d = pflag_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (in_frame) begin
      cnt_d = (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;
      if (cnt_q == HALF - 16'd1) samp_d[1] = rx_s;
      if (cnt_q == HALF)         samp_d[0] = rx_s;
    end

    if (state_q == IDLE) begin
      bit_d   = '0;
      pflag_d = 1'b0;
    end

    if (decide && state_q == DATA) begin
      shift_d = {maj, shift_q[7:1]};
      bit_d   = bit_q + 3'd1;
    end
    if (decide && state_q == PARITY && maj != parity_calc(shift_q, ODD))
      pflag_d = 1'b1;

    if (valid_q && rx_ready_i) valid_d = 1'b0;

    // a completing byte may refill the register in the same cycle it is drained
    if (done) begin
      ferr_d = !maj;
      if (accept) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        perr_d  = pflag_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      samp_q  <= '0;
      pflag_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      samp_q  <= samp_d;
      pflag_q <= pflag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign frame_err_o   = ferr_q;
  assign parity_err_o  = perr_q;
  assign overrun_err_o = ovr_q;
  assign busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_arty_uart_rx.sv
// Bench for arty_uart_rx: instance 0 is 8N1, instance 1 is 8E1, both at 16 clocks/bit.
module tb_arty_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  typedef struct {
    logic [7:0] d;
    bit         ferr;
    bit         perr;
    int         lo;
    int         hi;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      rx, rdy, vld, fe, pe, oe, bsy;
  logic [1:0][7:0] dat;

  int n_chk = 0, n_pass = 0, cyc = 0;

  exp_t       pend[2][$];
  bit         m_valid[2];
  logic [7:0] m_data[2];
  bit         p_valid[2], p_ready[2];
  logic [7:0] p_data[2];
  bit         prev_rst = 1'b1;
  int         n_fe[2], n_pe[2], n_oe[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arty_uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .rx_i(rx[0]), .rx_data_o(dat[0]), .rx_valid_o(vld[0]),
    .rx_ready_i(rdy[0]), .frame_err_o(fe[0]), .parity_err_o(pe[0]),
    .overrun_err_o(oe[0]), .busy_o(bsy[0]));

  arty_uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .rx_i(rx[1]), .rx_data_o(dat[1]), .rx_valid_o(vld[1]),
    .rx_ready_i(rdy[1]), .frame_err_o(fe[1]), .parity_err_o(pe[1]),
    .overrun_err_o(oe[1]), .busy_o(bsy[1]));

  function automatic void chk(input string nm, input int k, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] got %0h want %0h @cyc %0d", nm, k, act, exp, cyc);
  endfunction

  function automatic void bad(input string nm, input int k);
    n_chk++;
    $display("FAIL %s[%0d] got event want none @cyc %0d", nm, k, cyc);
  endfunction

  // Model: queue of expected frames plus the one-deep holding register.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit   done, acc, e_f, e_p, e_o;
      exp_t h;
      e_f = 0; e_p = 0; e_o = 0;
      n_fe[k] += int'(fe[k]);
      n_pe[k] += int'(pe[k]);
      n_oe[k] += int'(oe[k]);
      if (prev_rst) begin
        m_valid[k] = 0;
        m_data[k]  = 8'h00;
        pend[k].delete();
        chk("rst_data", k, dat[k], 8'h00);
      end else begin
        if (pend[k].size() > 0 && cyc > pend[k][0].hi) begin
          h = pend[k].pop_front();
          n_chk++;
          $display("FAIL no_completion[%0d] got none want byte %0h by cyc %0d", k, h.d, h.hi);
        end
        done = fe[k] || pe[k] || oe[k] ||
               (vld[k] && (!p_valid[k] || dat[k] !== p_data[k]));
        if (done) begin
          if (pend[k].size() == 0 || cyc < pend[k][0].lo - 1) bad("spurious_completion", k);
          else begin
            h = pend[k].pop_front();
            chk("done_time", k, (cyc >= h.lo), 1);
            acc = !m_valid[k] || p_ready[k];
            if (acc) begin
              m_valid[k] = 1;
              m_data[k]  = h.d;
              e_p        = h.perr;
            end else e_o = 1;
            e_f = h.ferr;
          end
        end else if (m_valid[k] && p_ready[k]) m_valid[k] = 0;
      end
      chk("valid", k, vld[k], m_valid[k]);
      chk("err_pulses", k, {fe[k], pe[k], oe[k]}, {e_f, e_p, e_o});
      if (m_valid[k]) chk("data", k, dat[k], m_data[k]);
      p_valid[k] = vld[k];
      p_data[k]  = dat[k];
      p_ready[k] = rdy[k];
    end
    prev_rst = rst;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int k, input logic [7:0] d, input bit has_par,
                      input bit pbit, input bit stop);
    exp_t e;
    int   nb;
    nb     = has_par ? 11 : 10;
    e.d    = d;
    e.ferr = !stop;
    e.perr = has_par && (pbit != ^d);
    e.lo   = cyc + HALF + 4 + (nb - 1) * CPB - 1;
    e.hi   = cyc + HALF + 4 + (nb - 1) * CPB + 2;
    pend[k].push_back(e);
    rx[k] = 1'b0; step(CPB);
    for (int i = 0; i < 8; i++) begin rx[k] = d[i]; step(CPB); end
    if (has_par) begin rx[k] = pbit; step(CPB); end
    rx[k] = stop; step(CPB);
  endtask

  task automatic consume0();
    rdy[0] = 1'b1; step(1); rdy[0] = 1'b0;
  endtask

  initial begin
    int hi;
    rx = 2'b11; rdy = 2'b10; rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      p_data[k] = 8'h00; n_fe[k] = 0; n_pe[k] = 0; n_oe[k] = 0;
    end
    step(3); rst = 1'b0;
    step(3);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, vld[k], 0);
      chk("rst_busy", k, bsy[k], 0);
    end
    step(1);

    // 1: 0xA5 held for 50 cycles, then drained
    send(0, 8'hA5, 0, 0, 1);
    step(50);
    @(negedge clk);
    chk("t1_data", 0, dat[0], 8'hA5);
    chk("t1_valid", 0, vld[0], 1);
    chk("t1_errs", 0, n_fe[0] + n_pe[0] + n_oe[0], 0);
    step(1); rdy[0] = 1'b1; step(1); rdy[0] = 1'b0;
    @(negedge clk);
    chk("t1_drop", 0, vld[0], 0);
    step(1);

    // 2: 3-cycle glitch
    rx[0] = 1'b0; step(3); rx[0] = 1'b1;
    hi = 0;
    repeat (HALF + 10) begin @(negedge clk); if (bsy[0]) hi++; end
    chk("t2_busy_seen", 0, (hi != 0), 1);
    chk("t2_busy_len", 0, (hi <= HALF + 2), 1);
    chk("t2_busy_end", 0, bsy[0], 0);
    step(1);

    // 3: bad stop bit, then line held low
    send(0, 8'h3C, 0, 0, 0);
    step(40);
    @(negedge clk);
    chk("t3_busy_low", 0, bsy[0], 1);
    chk("t3_ferr_cnt", 0, n_fe[0], 1);
    chk("t3_data", 0, dat[0], 8'h3C);
    step(1); rx[0] = 1'b1; step(5);
    @(negedge clk);
    chk("t3_busy_end", 0, bsy[0], 0);
    chk("t3_ferr_once", 0, n_fe[0], 1);
    step(1); consume0();

    // 4: overrun, then streaming with ready held high
    send(0, 8'h11, 0, 0, 1);
    send(0, 8'h22, 0, 0, 1);
    step(3);
    @(negedge clk);
    chk("t4_data", 0, dat[0], 8'h11);
    chk("t4_ovr", 0, n_oe[0], 1);
    step(1); rdy[0] = 1'b1;
    send(0, 8'h33, 0, 0, 1);
    send(0, 8'h44, 0, 0, 1);
    step(3);
    @(negedge clk);
    chk("t4_ovr_none", 0, n_oe[0], 1);
    chk("t4_model_last", 0, m_data[0], 8'h44);
    chk("t4_drained", 0, vld[0], 0);
    step(1); rdy[0] = 1'b0;

    // 5: even parity on instance 1
    send(1, 8'h07, 1, 0, 1);
    step(3);
    @(negedge clk);
    chk("t5_perr", 1, n_pe[1], 1);
    chk("t5_model_data", 1, m_data[1], 8'h07);
    step(1);
    send(1, 8'h07, 1, 1, 1);
    step(3);
    @(negedge clk);
    chk("t5_perr_ok", 1, n_pe[1], 1);
    chk("t5_other_errs", 1, n_fe[1] + n_oe[1], 0);
    step(1);

    // 6: reset mid-frame with a byte pending
    send(0, 8'h66, 0, 0, 1);
    step(2);
    @(negedge clk);
    chk("t6_pending", 0, vld[0], 1);
    step(1);
    rx[0] = 1'b0; step(CPB);
    for (int i = 0; i < 4; i++) step(CPB);
    rx[0] = 1'b1; rst = 1'b1; step(1); rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", 0, vld[0], 0);
    chk("t6_busy", 0, bsy[0], 0);
    chk("t6_errs", 0, {fe[0], pe[0], oe[0]}, 3'b000);
    step(3);
    @(negedge clk);
    chk("t6_busy_after", 0, bsy[0], 0);
    step(6 * CPB - 4);
    @(negedge clk);
    chk("t6_no_byte", 0, vld[0], 0);
    step(1);
    send(0, 8'h5A, 0, 0, 1);
    step(3);
    @(negedge clk);
    chk("t6_data", 0, dat[0], 8'h5A);
    chk("t6_valid_new", 0, vld[0], 1);
    chk("pending_left", 0, pend[0].size() + pend[1].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/arty_uart_rx.md
Name: arty_uart_rx

Overview:
- UART receiver deserialising the serial line driven toward the FPGA on the Arty board (uart_txd_in pin).
- It is the receive counterpart of the SoC UART transmit path.
- Frames are 8 data bits, LSB first, one start bit, optional parity and one stop bit, at a fixed bit period in clock cycles.
- Received bytes are presented on a single-entry valid/ready output with framing, parity and overrun error pulses, for use by an APB UART wrapper or a debug loader.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200); legal range 8..65535.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_i  in  1  asynchronous serial input, idle high
- rx_data_o  out  8  received byte
- rx_valid_o  out  1  rx_data_o holds an unconsumed byte
- rx_ready_i  in  1  consumer accepts the byte when rx_valid_o & rx_ready_i
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- parity_err_o  out  1  one-cycle pulse: parity mismatch
- overrun_err_o  out  1  one-cycle pulse: byte completed while the holding register was full
- busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset values: all outputs 0; rx_data_o = 0x00; state IDLE; synchroniser flops = 1; bit counter, cycle counter and shift register = 0.
- Synchroniser: 2-flop synchroniser on rx_i gives rx_s. All decisions use rx_s, so there is a 2-cycle input latency.
- HALF = CLKS_PER_BIT/2 (integer division).
- Majority sampling: a bit value is the majority of rx_s at cycle counts HALF-1, HALF and HALF+1 within the bit. The decision is taken at count HALF+1.
- Counting: the cycle counter is reset to 0 on entering START. The counter is 16 bits and wraps at CLKS_PER_BIT-1.
- IDLE: rx_s == 0 moves to START.
- START: at the decision, if the majority is 1 the low was a glitch; return to IDLE with no error and no output. If the majority is 0, go to DATA with the counter free-running, so each later decision is exactly CLKS_PER_BIT cycles after the previous one.
- DATA: each decision shifts the bit into the MSB (right shift); the bit index runs 0..7. After bit 7, go to PARITY if PARITY_EN, else STOP.
- PARITY: the expected bit is XOR(data) ^ PARITY_ODD. On mismatch, a parity-error flag is latched for this frame. Then go to STOP.
- STOP, majority 1: the byte completes and the state returns to IDLE.
- STOP, majority 0: the byte still completes and frame_err_o pulses. The state goes to WAIT_HIGH, which stays until rx_s == 1 and then returns to IDLE. A break condition therefore produces one frame error, not repeated frames.
- Completion (same cycle as the stop decision, outputs visible next cycle):
  - If rx_valid_o == 0, or rx_valid_o & rx_ready_i in that same cycle: load rx_data_o, set rx_valid_o = 1, and pulse parity_err_o if the flag is latched.
  - Otherwise: pulse overrun_err_o; the new byte and its parity error are dropped and rx_data_o is unchanged.
- Handshake:
  - rx_valid_o & rx_ready_i clears rx_valid_o next cycle unless a byte completes in the same cycle.
  - rx_data_o is stable while rx_valid_o = 1.
  - rx_ready_i while rx_valid_o = 0 has no effect.
- Latency: from the first rx_i low edge to rx_valid_o high is 2 + (HALF+1) + 9·CLKS_PER_BIT (+CLKS_PER_BIT with parity) + 1 cycles, ±1 for input edge phase.
- Reset mid-frame: everything returns to reset values, any pending byte is discarded, and there are no error pulses. If rx_i is low when reset deasserts, START is entered as a normal start candidate.
- No back-to-back limit: a new start bit is detected in the cycle after returning to IDLE.

Decomposition:
- uart_pkg:
  - state enum rx_state_e {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH};
  - function parity_calc(byte, odd);
  - localparam for the default 115200 @ 100 MHz divisor.
- Sub-module arty_uart_sync2: generic 2-flop synchroniser with a reset value parameter, reusable for the button and switch inputs.

Test Plan:
All cases use CLKS_PER_BIT = 16 unless noted.
1. Send 0xA5 (8N1) with rx_ready_i = 0. Expect rx_valid_o = 1 and rx_data_o = 0xA5, held stable for 50 cycles, with no error pulses. Assert rx_ready_i for 1 cycle; rx_valid_o drops next cycle.
2. Drive a 3-cycle low glitch on an idle line. Expect no rx_valid_o, no errors, busy_o returning to 0 within HALF+2 cycles.
3. Send 0x3C with stop bit = 0, then hold the line low for 40 cycles. Expect exactly one frame_err_o pulse and rx_data_o = 0x3C valid. busy_o stays 1 until the line goes high, and no second frame is received.
4. Send 0x11 then 0x22 back-to-back with rx_ready_i = 0. Expect an overrun_err_o pulse at the second completion and rx_data_o still 0x11. Then handshake with rx_ready_i = 1 continuously and send 0x33 and 0x44; expect both received with no overrun.
5. With PARITY_EN = 1 and even parity, send 0x07 with parity bit 0. Expect parity_err_o pulse and rx_data_o = 0x07. Send 0x07 with parity bit 1; expect no error.
6. Assert rst for 1 cycle after data bit 3 of a frame. Expect all outputs 0. The remainder of the frame must not produce a valid byte; a following clean 0x5A is received correctly (allow one idle bit time after the aborted frame).
